// File: rtl/ram_initiator.sv
// Burst initiator bridging a command/write stream and a read-return FIFO onto a RAM port.
// Optional read timeout is enabled with `define RAM_INITIATOR_TIMEOUT_EN.
module ram_initiator #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_rw,
    input  logic [15:0]  cmd_addr,
    input  logic         s_wr_valid,
    output logic         s_wr_ready,
    input  logic [527:0] s_wr_data,
    input  logic         s_wr_last,
    output logic         m_rd_valid,
    input  logic         m_rd_ready,
    output logic [527:0] m_rd_data,
    output logic         m_rd_last,
    output logic         ram_valid,
    input  logic         ram_ready,
    output logic [527:0] ram_data,
    output logic [15:0]  ram_addr,
    output logic         ram_rw,
    input  logic         ram_rx_valid,
    input  logic [527:0] ram_rx_data,
    output logic         ram_rx_ready,
    output logic         err_pulse
);

    typedef enum logic [2:0] {IDLE, WR, WR_PAD, RD_REQ, RD_DATA} state_t;

    state_t       state;
    logic [15:0]  base;
    logic [2:0]   last_idx;
    logic [2:0]   cnt;
    logic [3:0]   cmd_beats;
    logic [3:0]   free;
    logic         cmd_hs;
    logic         wr_hs;
    logic         push;
    logic         pop;
    logic         last_beat;
    logic         timeout;

    logic [527:0] mem [8];
    logic [7:0]   lastq;
    logic [2:0]   wptr;
    logic [2:0]   rptr;
    logic [3:0]   count;

    assign cmd_beats = 4'd1 << cmd_addr[15:14];
    assign free      = 4'd8 - count;
    assign cmd_ready = (state == IDLE) && (cmd_rw || free >= cmd_beats);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign wr_hs     = (state == WR) && s_wr_valid && ram_ready;
    assign push      = (state == RD_DATA) && ram_rx_valid;
    assign pop       = m_rd_valid && m_rd_ready;
    assign last_beat = (cnt == last_idx);

`ifdef RAM_INITIATOR_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign timeout = (state == RD_DATA) && !push
                  && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state != RD_DATA || push)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            last_idx  <= '0;
            cnt       <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            unique case (state)
                IDLE: if (cmd_hs) begin
                    base     <= cmd_addr;
                    last_idx <= 3'(cmd_beats - 4'd1);
                    cnt      <= '0;
                    state    <= cmd_rw ? WR : RD_REQ;
                end
                WR: if (wr_hs) begin
                    if (last_beat) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        // early last: pad the rest of the burst with zeros
                        if (s_wr_last) begin
                            state     <= WR_PAD;
                            err_pulse <= 1'b1;
                        end
                    end
                end
                WR_PAD: if (ram_ready) begin
                    if (last_beat) state <= IDLE;
                    else           cnt   <= cnt + 3'd1;
                end
                RD_REQ: if (ram_ready) state <= RD_DATA;
                RD_DATA: begin
                    if (push) begin
                        if (last_beat) state <= IDLE;
                        else           cnt   <= cnt + 3'd1;
                    end else if (timeout) begin
                        state     <= IDLE;
                        err_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= ram_rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            lastq <= '0;
        end else begin
            if (push) begin
                lastq[wptr] <= last_beat;
                wptr        <= wptr + 3'd1;
            end
            // a truncated burst still gets a terminating beat if one is queued
            if (timeout && count > {3'd0, pop})
                lastq[wptr - 3'd1] <= 1'b1;
            if (pop) rptr <= rptr + 3'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: ;
            endcase
        end
    end

    assign m_rd_valid   = (count != 4'd0);
    assign m_rd_data    = m_rd_valid ? mem[rptr] : '0;
    assign m_rd_last    = m_rd_valid & lastq[rptr];
    assign ram_addr     = base;
    assign ram_rx_ready = 1'b1;

    always_comb begin
        ram_valid  = 1'b0;
        ram_rw     = 1'b0;
        ram_data   = '0;
        s_wr_ready = 1'b0;
        unique case (state)
            WR: begin
                ram_valid  = s_wr_valid;
                s_wr_ready = ram_ready;
                ram_data   = s_wr_data;
                ram_rw     = 1'b1;
            end
            WR_PAD: begin
                ram_valid = 1'b1;
                ram_rw    = 1'b1;
            end
            RD_REQ:  ram_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_initiator.sv
// Scoreboard bench for ram_initiator: expected RAM and read-stream beats are
// queued by the stimulus and checked by independent monitors.
module tb_ram_initiator;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, cmd_rw;
    logic [15:0]  cmd_addr;
    logic         s_wr_valid, s_wr_ready, s_wr_last;
    logic [527:0] s_wr_data;
    logic         m_rd_valid, m_rd_ready, m_rd_last;
    logic [527:0] m_rd_data;
    logic         ram_valid, ram_ready, ram_rw;
    logic [527:0] ram_data;
    logic [15:0]  ram_addr;
    logic         ram_rx_valid, ram_rx_ready;
    logic [527:0] ram_rx_data;
    logic         err_pulse;

    ram_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
        .s_wr_data(s_wr_data), .s_wr_last(s_wr_last),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
        .m_rd_data(m_rd_data), .m_rd_last(m_rd_last),
        .ram_valid(ram_valid), .ram_ready(ram_ready),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_rw(ram_rw),
        .ram_rx_valid(ram_rx_valid), .ram_rx_data(ram_rx_data),
        .ram_rx_ready(ram_rx_ready), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic         rw;
        logic [527:0] data;
    } ram_t;

    typedef struct {
        logic [527:0] data;
        logic         last;
    } rd_t;

    ram_t ram_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ram_beats = 0;
    int   err_cnt = 0;

    function automatic logic [527:0] pat(input logic [15:0] k);
        return {33{k}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_ram(input logic [15:0] a, input logic rw,
                              input logic [527:0] d);
        ram_t e;
        e.addr = a; e.rw = rw; e.data = d;
        ram_q.push_back(e);
    endtask

    task automatic expect_rd(input logic [527:0] d, input logic l);
        rd_t e;
        e.data = d; e.last = l;
        rd_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ram_t e;
        if (rst_n && ram_valid && ram_ready) begin
            ram_beats++;
            checks++;
            if (ram_q.size() == 0) begin
                errors++;
                $display("FAIL ram_unexpected addr=%0h rw=%0b", ram_addr, ram_rw);
            end else begin
                e = ram_q.pop_front();
                if (ram_addr !== e.addr || ram_rw !== e.rw || ram_data !== e.data) begin
                    errors++;
                    $display("FAIL ram_beat actual a=%0h rw=%0b d=%0h required a=%0h rw=%0b d=%0h",
                             ram_addr, ram_rw, ram_data[31:0], e.addr, e.rw, e.data[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        rd_t e;
        if (rst_n && m_rd_valid && m_rd_ready) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected d=%0h last=%0b", m_rd_data[31:0], m_rd_last);
            end else begin
                e = rd_q.pop_front();
                if (m_rd_data !== e.data || m_rd_last !== e.last) begin
                    errors++;
                    $display("FAIL rd_beat actual d=%0h last=%0b required d=%0h last=%0b",
                             m_rd_data[31:0], m_rd_last, e.data[31:0], e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && err_pulse) err_cnt++;
    end

    task automatic send_cmd(input logic rw, input logic [15:0] a);
        int n = 0;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [527:0] d, input logic l);
        int n = 0;
        s_wr_valid = 1'b1; s_wr_data = d; s_wr_last = l;
        @(negedge clk);
        while (!s_wr_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_wr_ready) chk("wr_beat_accept", s_wr_ready, 1);
        @(posedge clk); #1;
        s_wr_valid = 1'b0; s_wr_last = 1'b0;
    endtask

    task automatic rd_req_wait;
        int n = 0;
        @(negedge clk);
        while (!(ram_valid && ram_ready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ram_valid) chk("rd_req_seen", ram_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic rx_beat(input logic [527:0] d);
        ram_rx_valid = 1'b1; ram_rx_data = d;
        @(posedge clk); #1;
        ram_rx_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        cmd_rw = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int b0;
        int e0;
        rst_n = 1'b1;
        cmd_valid = 0; cmd_rw = 0; cmd_addr = '0;
        s_wr_valid = 0; s_wr_last = 0; s_wr_data = '0;
        m_rd_ready = 0; ram_ready = 1;
        ram_rx_valid = 0; ram_rx_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_s_wr_ready", s_wr_ready, 0);
        chk("rst_m_rd_valid", m_rd_valid, 0);
        chk("rst_m_rd_last", m_rd_last, 0);
        chk("rst_m_rd_data", (m_rd_data == '0), 1);
        chk("rst_ram_valid", ram_valid, 0);
        chk("rst_ram_rw", ram_rw, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", (ram_data == '0), 1);
        chk("rst_rx_ready", ram_rx_ready, 1);
        chk("rst_err", err_pulse, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // two-beat write with last on the final beat
        expect_ram(16'h4010, 1'b1, pat(16'hAAAA));
        expect_ram(16'h4010, 1'b1, pat(16'hBBBB));
        send_cmd(1'b1, 16'h4010);
        wr_beat(pat(16'hAAAA), 1'b0);
        wr_beat(pat(16'hBBBB), 1'b1);
        @(negedge clk);
        chk("wr2_idle", cmd_ready, 1);
        chk("wr2_s_wr_ready", s_wr_ready, 0);
        chk("wr2_err", err_cnt, 0);
        @(posedge clk); #1;

        // short 8-beat write padded with zeros, with a RAM stall first
        for (int i = 1; i <= 3; i++) expect_ram(16'hC000, 1'b1, pat(16'(i)));
        for (int i = 4; i <= 8; i++) expect_ram(16'hC000, 1'b1, '0);
        b0 = ram_beats;
        send_cmd(1'b1, 16'hC000);
        ram_ready = 1'b0; s_wr_valid = 1'b1; s_wr_data = pat(16'd1);
        @(negedge clk);
        chk("stall_s_wr_ready", s_wr_ready, 0);
        chk("stall_ram_valid", ram_valid, 1);
        @(posedge clk); #1 ram_ready = 1'b1;
        wr_beat(pat(16'd1), 1'b0);
        wr_beat(pat(16'd2), 1'b0);
        wr_beat(pat(16'd3), 1'b1);
        wait_idle;
        chk("pad_beats", ram_beats - b0, 8);
        chk("pad_err", err_cnt, 1);

        // missing last: burst ends anyway, extra beat stalls
        expect_ram(16'h0100, 1'b1, pat(16'd4));
        send_cmd(1'b1, 16'h0100);
        wr_beat(pat(16'd4), 1'b0);
        s_wr_valid = 1'b1; s_wr_data = pat(16'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nolast_stall", s_wr_ready, 0);
        end
        @(posedge clk); #1 s_wr_valid = 1'b0;
        chk("nolast_err", err_cnt, 1);

        // class-2 read into a stalled FIFO
        expect_ram(16'h8000, 1'b0, '0);
        for (int i = 0; i < 4; i++) expect_rd(pat(16'(16 + i)), i == 3);
        send_cmd(1'b0, 16'h8000);
        rd_req_wait;
        for (int i = 0; i < 4; i++) rx_beat(pat(16'(16 + i)));
        ram_rx_valid = 1'b1; ram_rx_data = pat(16'd99);
        cmd_rw = 1'b0; cmd_addr = 16'h8000;
        @(negedge clk);
        chk("fifo_valid", m_rd_valid, 1);
        chk("rd_class2_room", cmd_ready, 1);
        cmd_addr = 16'hC000;
        @(negedge clk);
        chk("rd_class3_blocked", cmd_ready, 0);
        @(posedge clk); #1 ram_rx_valid = 1'b0;
        m_rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_rd_valid) break;
            chk("rd_drain_blocked", cmd_ready, 0);
        end
        chk("rd_class3_free", cmd_ready, 1);
        @(posedge clk); #1;

        // class-3 read with simultaneous push and pop
        expect_ram(16'hC000, 1'b0, '0);
        for (int i = 0; i < 8; i++) expect_rd(pat(16'(32 + i)), i == 7);
        send_cmd(1'b0, 16'hC000);
        rd_req_wait;
        for (int i = 0; i < 8; i++) rx_beat(pat(16'(32 + i)));
        repeat (3) @(posedge clk);
        #1;

        // class-0 read, released after it lands
        m_rd_ready = 1'b0;
        expect_ram(16'h0123, 1'b0, '0);
        expect_rd(pat(16'd50), 1'b1);
        send_cmd(1'b0, 16'h0123);
        rd_req_wait;
        rx_beat(pat(16'd50));
        @(negedge clk);
        chk("c0_last", m_rd_last, 1);
        @(posedge clk); #1 m_rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset during beat 2 of a 4-beat write
        expect_ram(16'h8000, 1'b1, pat(16'd60));
        send_cmd(1'b1, 16'h8000);
        wr_beat(pat(16'd60), 1'b0);
        s_wr_valid = 1'b1; s_wr_data = pat(16'd61);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_valid", ram_valid, 0);
        chk("mid_rst_s_wr_ready", s_wr_ready, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        s_wr_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        expect_ram(16'h0042, 1'b1, pat(16'd62));
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h0042;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_wr", s_wr_ready, 1);
        @(posedge clk); #1;
        wr_beat(pat(16'd62), 1'b1);
        wait_idle;

`ifdef RAM_INITIATOR_TIMEOUT_EN
        // read timeout after two of four beats
        m_rd_ready = 1'b0;
        expect_ram(16'h8000, 1'b0, '0);
        expect_rd(pat(16'd70), 1'b0);
        expect_rd(pat(16'd71), 1'b1);
        send_cmd(1'b0, 16'h8000);
        rd_req_wait;
        rx_beat(pat(16'd70));
        rx_beat(pat(16'd71));
        e0 = err_cnt;
        begin
            int n = 0;
            while (err_cnt == e0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_err", err_cnt - e0, 1);
            chk("tmo_not_early", (n >= 250), 1);
        end
        @(posedge clk); #1;
        wait_idle;
        m_rd_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
`else
        e0 = err_cnt;
        chk("no_tmo_err", err_cnt - e0, 0);
`endif

        chk("ram_q_empty", ram_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
